// File: rtl/debounce_pkg.sv
// ============================================================================
// debounce_pkg : shared defaults and helpers for the push-button debouncer
// Revision     : 1.0
// ============================================================================
`default_nettype none

package debounce_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

  localparam int MIN_SYNC_STAGES   = 2;
  localparam int MAX_SYNC_STAGES   = 4;
  localparam int MIN_STABLE_CYCLES = 2;
  localparam int MAX_STABLE_CYCLES = 65535;

  // Counter width never drops below one bit, even for tiny stable counts.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : debounce_pkg

`default_nettype wire

// File: rtl/sync_chain.sv
// ============================================================================
// sync_chain : STAGES-deep flop chain bringing an asynchronous level into clk
// Revision   : 1.0
// ============================================================================
`default_nettype none

module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule : sync_chain

`default_nettype wire

// File: rtl/debounce_circuit.sv
// ============================================================================
// debounce_circuit : synchronizes a bouncing button and accepts a new level
//                    only after it persists for STABLE_CYCLES clocks
// Revision         : 1.0
// ============================================================================
`default_nettype none

module debounce_circuit
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic result,
  output logic result_rise,
  output logic result_fall
);

  localparam int              CNT_W   = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  generate
    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
      $error("debounce_circuit: SYNC_STAGES out of range");
    end
    if (STABLE_CYCLES < MIN_STABLE_CYCLES || STABLE_CYCLES > MAX_STABLE_CYCLES) begin : g_bad_stable
      $error("debounce_circuit: STABLE_CYCLES out of range");
    end
  endgenerate

  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (button),
    .q     (sync_q)
  );

  // Any return to the current level restarts the count; acceptance happens on
  // the clock where the count has already reached STABLE_CYCLES-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      result      <= 1'b0;
      result_rise <= 1'b0;
      result_fall <= 1'b0;
    end else begin
      result_rise <= 1'b0;
      result_fall <= 1'b0;
      if (sync_q == result) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt         <= '0;
        result      <= sync_q;
        result_rise <= sync_q;
        result_fall <= ~sync_q;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : debounce_circuit

`default_nettype wire

// File: tb/tb_debounce_circuit.sv
// ============================================================================
// tb_debounce_circuit : scoreboard bench for debounce_circuit (10 ns clock)
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_debounce_circuit;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int LAT    = SYNC + STABLE;

  logic clk = 1'b0;
  logic reset;
  logic button;
  logic result, result_rise, result_fall;

  debounce_circuit #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button      (button),
    .result      (result),
    .result_rise (result_rise),
    .result_fall (result_fall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic res;
    logic rise;
    logic fall;
  } exp_t;

  exp_t sb_q[$];

  // Reference: a level is accepted once the last STABLE synchronized samples
  // all disagree with the current result.
  logic [SYNC-1:0]   m_sync = '0;
  logic [STABLE-1:0] m_win  = '0;
  logic              m_res  = 1'b0;

  always @(posedge clk) begin
    logic q, flip;
    exp_t e;
    if (reset) begin
      m_sync = '0;
      m_win  = '0;
      m_res  = 1'b0;
      e      = '0;
    end else begin
      q      = m_sync[SYNC-1];
      m_win  = {m_win[STABLE-2:0], q};
      flip   = (m_win == {STABLE{~m_res}});
      m_sync = {m_sync[SYNC-2:0], button};
      if (flip) m_res = ~m_res;
      e.res  = m_res;
      e.rise = flip & m_res;
      e.fall = flip & ~m_res;
    end
    sb_q.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_result", int'(result), int'(e.res));
      check("sb_rise", int'(result_rise), int'(e.rise));
      check("sb_fall", int'(result_fall), int'(e.fall));
    end else begin
      check("sb_empty", 0, 1);
    end
    check("rise_fall_excl", int'(result_rise & result_fall), 0);
    if (result_rise === 1'b1) rise_cnt++;
    if (result_fall === 1'b1) fall_cnt++;
  end

  task automatic measure(input logic target, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (result === target) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, r0, f0;
    reset  = 1'b1;
    button = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", int'(result), 0);
    check("rst_rise", int'(result_rise), 0);
    check("rst_fall", int'(result_fall), 0);
    @(negedge clk) reset = 1'b0;
    measure(1'b1, n);
    check("rst_release_lat", n, LAT);
    @(negedge clk) button = 1'b0;
    repeat (10) @(posedge clk);

    // clean press and release, 90 ns each
    @(negedge clk);
    r0 = rise_cnt; f0 = fall_cnt;
    button = 1'b1;
    measure(1'b1, n);
    check("press_lat", n, LAT);
    repeat (9 - LAT) @(posedge clk);
    @(negedge clk) button = 1'b0;
    measure(1'b0, n);
    check("release_lat", n, LAT);
    repeat (9 - LAT) @(posedge clk);
    @(negedge clk);
    check("press_rise_cnt", rise_cnt - r0, 1);
    check("press_fall_cnt", fall_cnt - f0, 1);

    // 10 ns glitches
    r0 = rise_cnt; f0 = fall_cnt;
    repeat (5) begin
      #2 button = 1'b1;
      #10 button = 1'b0;
      #8;
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("glitch_result", int'(result), 0);
    check("glitch_rise_cnt", rise_cnt - r0, 0);
    check("glitch_fall_cnt", fall_cnt - f0, 0);

    // 20 ns bounces for 80 ns
    r0 = rise_cnt;
    repeat (2) begin
      #2 button = 1'b1;
      #20 button = 1'b0;
      #18;
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("bounce_result", int'(result), 0);
    check("bounce_rise_cnt", rise_cnt - r0, 0);

    // mixed: 10 ns high, 47 ns low, 57 ns high
    r0 = rise_cnt; f0 = fall_cnt;
    #2 button = 1'b1;
    #10 button = 1'b0;
    #47 button = 1'b1;
    #57;
    check("mixed_result", int'(result), 1);
    button = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mixed_rise_cnt", rise_cnt - r0, 1);
    check("mixed_fall_cnt", fall_cnt - f0, 1);

    // reset in the middle of a count
    button = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_result", int'(result), 0);
    @(negedge clk) reset = 1'b0;
    measure(1'b1, n);
    check("midrst_lat", n, LAT);
    @(negedge clk) button = 1'b0;
    repeat (8) @(posedge clk);

    // reset lands on the would-be acceptance edge
    @(negedge clk) button = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("prio_result", int'(result), 0);
    check("prio_rise", int'(result_rise), 0);
    @(negedge clk) begin
      reset  = 1'b0;
      button = 1'b0;
    end
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_debounce_circuit

`default_nettype wire
